// File: rtl/pic_interrupt_sequencer_if.sv
// ============================================================================
// Module      : pic_interrupt_sequencer_if
// Description : CPU-side bus of the PIC interrupt core: IR lines, INTA
//               handshake, status-read control and internal data bus drive.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pic_interrupt_sequencer_if;
    logic [7:0] ir;
    logic       inta_n;
    logic       rd_status_en;
    logic       ocw3_ris;
    logic       intr;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output ir, inta_n, rd_status_en, ocw3_ris,
        input  intr, data_out, data_oe
    );

    modport slave (
        input  ir, inta_n, rd_status_en, ocw3_ris,
        output intr, data_out, data_oe
    );
endinterface

`default_nettype wire

// File: rtl/pic_interrupt_sequencer.sv
// ============================================================================
// Module      : pic_interrupt_sequencer
// Description : 8259A interrupt core - IRR capture, rotating priority with
//               fully nested ISR, 8086-mode two-pulse INTA, OCW2 EOI/rotate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_interrupt_sequencer (
    input  wire logic                            clk,
    input  wire logic                            reset_n,
    pic_interrupt_sequencer_if.slave             bus,
    input  wire logic [7:0]                      imr,
    input  wire logic                            init_done,
    input  wire logic                            icw1_ltim,
    input  wire logic [4:0]                      icw2_vec,
    input  wire logic                            icw4_aeoi,
    input  wire logic [7:0]                      ocw2,
    input  wire logic                            ocw2_wr,
    output logic [7:0]                           irr,
    output logic [7:0]                           isr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACK1  = 2'd1;
    localparam logic [1:0] c_WAIT2 = 2'd2;
    localparam logic [1:0] c_ACK2  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [2:0] r_lp;
    logic       r_rot_aeoi;
    logic [2:0] r_idx;
    logic [7:0] r_ir_q;
    logic       r_inta_s;
    logic       r_inta_d;
    logic       r_intr;

    logic [2:0] w_base;
    logic [7:0] w_req;
    logic [3:0] w_cand_rank;
    logic [3:0] w_isr_rank;
    logic       w_cand_valid;
    logic       w_isr_valid;
    logic [2:0] w_cand_idx;
    logic [2:0] w_isr_idx;
    logic       w_inta_fall;
    logic       w_inta_rise;
    logic       w_ack1;
    logic       w_ack2_done;
    logic [7:0] w_ack_set;
    logic [7:0] w_aeoi_clr;
    logic [7:0] w_eoi_clr;
    logic       w_lp_wr;
    logic [2:0] w_lp_val;
    logic       w_rot_wr;
    logic       w_rot_val;
    logic [7:0] w_irr_next;
    logic [7:0] w_isr_next;
    logic       w_intr_next;
    logic [2:0] w_ocw_cmd;
    logic [2:0] w_ocw_lvl;
    logic       w_ocw_valid;

    // Rank 0 is the highest priority; 8 means no bit set.
    function automatic logic [3:0] top_rank(input logic [7:0] v, input logic [2:0] base);
        logic [3:0] r;
        r = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (v[base + 3'(k)]) r = 4'(k);
        end
        return r;
    endfunction

    assign w_base       = r_lp + 3'd1;
    assign w_req        = irr & ~imr;
    assign w_cand_rank  = top_rank(w_req, w_base);
    assign w_isr_rank   = top_rank(isr, w_base);
    assign w_cand_valid = ~w_cand_rank[3];
    assign w_isr_valid  = ~w_isr_rank[3];
    assign w_cand_idx   = w_base + w_cand_rank[2:0];
    assign w_isr_idx    = w_base + w_isr_rank[2:0];

    assign w_inta_fall  = r_inta_d & ~r_inta_s;
    assign w_inta_rise  = ~r_inta_d & r_inta_s;
    assign w_ack1       = (r_state == c_IDLE) && w_inta_fall;
    assign w_ack2_done  = (r_state == c_ACK2) && w_inta_rise;
    assign w_ack_set    = (w_ack1 && w_cand_valid) ? (8'd1 << w_cand_idx) : 8'd0;
    assign w_aeoi_clr   = (w_ack2_done && icw4_aeoi) ? (8'd1 << r_idx) : 8'd0;

    // OCW2 is told apart from OCW3/ICW by D4:D3 = 00.
    assign w_ocw_cmd    = ocw2[7:5];
    assign w_ocw_lvl    = ocw2[2:0];
    assign w_ocw_valid  = ocw2_wr && (ocw2[4:3] == 2'b00);

    always_comb begin
        w_eoi_clr = 8'd0;
        w_lp_wr   = 1'b0;
        w_lp_val  = r_lp;
        w_rot_wr  = 1'b0;
        w_rot_val = r_rot_aeoi;
        if (w_ocw_valid) begin
            case (w_ocw_cmd)
                3'b001: if (w_isr_valid) w_eoi_clr = 8'd1 << w_isr_idx;
                3'b011: w_eoi_clr = 8'd1 << w_ocw_lvl;
                3'b101: begin
                    if (w_isr_valid) begin
                        w_eoi_clr = 8'd1 << w_isr_idx;
                        w_lp_wr   = 1'b1;
                        w_lp_val  = w_isr_idx;
                    end
                end
                3'b111: begin
                    w_eoi_clr = 8'd1 << w_ocw_lvl;
                    w_lp_wr   = 1'b1;
                    w_lp_val  = w_ocw_lvl;
                end
                3'b110: begin
                    w_lp_wr  = 1'b1;
                    w_lp_val = w_ocw_lvl;
                end
                3'b100: begin
                    w_rot_wr  = 1'b1;
                    w_rot_val = 1'b1;
                end
                3'b000: begin
                    w_rot_wr  = 1'b1;
                    w_rot_val = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (icw1_ltim)
            w_irr_next = bus.ir;
        else
            w_irr_next = (irr | (bus.ir & ~r_ir_q)) & bus.ir;
        w_irr_next = w_irr_next & ~w_ack_set;
    end

    // The EOI acts on the pre-acknowledge ISR; the new in-service bit is ORed in last.
    assign w_isr_next  = (isr & ~w_eoi_clr & ~w_aeoi_clr) | w_ack_set;
    assign w_intr_next = (r_state == c_IDLE) && !w_inta_fall && w_cand_valid &&
                         (w_cand_rank < w_isr_rank);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_inta_fall) w_state_next = c_ACK1;
            c_ACK1:  if (w_inta_rise) w_state_next = c_WAIT2;
            c_WAIT2: if (w_inta_fall) w_state_next = c_ACK2;
            c_ACK2:  if (w_inta_rise) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_q     <= 8'd0;
            r_inta_s   <= 1'b1;
            r_inta_d   <= 1'b1;
            r_state    <= c_IDLE;
            r_lp       <= 3'd7;
            r_rot_aeoi <= 1'b0;
            r_idx      <= 3'd7;
            r_intr     <= 1'b0;
            irr        <= 8'd0;
            isr        <= 8'd0;
        end else begin
            r_ir_q   <= bus.ir;
            r_inta_s <= bus.inta_n;
            r_inta_d <= r_inta_s;
            if (!init_done) begin
                r_state    <= c_IDLE;
                r_lp       <= 3'd7;
                r_rot_aeoi <= 1'b0;
                r_idx      <= 3'd7;
                r_intr     <= 1'b0;
                irr        <= 8'd0;
                isr        <= 8'd0;
            end else begin
                r_state <= w_state_next;
                r_intr  <= w_intr_next;
                irr     <= w_irr_next;
                isr     <= w_isr_next;
                if (w_ack1)
                    r_idx <= w_cand_valid ? w_cand_idx : 3'd7;
                if (w_rot_wr)
                    r_rot_aeoi <= w_rot_val;
                if (w_lp_wr)
                    r_lp <= w_lp_val;
                else if (w_ack2_done && icw4_aeoi && r_rot_aeoi)
                    r_lp <= r_idx;
            end
        end
    end

    assign bus.intr = r_intr;

    always_comb begin
        bus.data_out = 8'd0;
        bus.data_oe  = 1'b0;
        if (r_state == c_ACK2) begin
            bus.data_out = {icw2_vec, r_idx};
            bus.data_oe  = 1'b1;
        end else if (bus.rd_status_en && (r_state == c_IDLE || r_state == c_ACK1)) begin
            bus.data_out = bus.ocw3_ris ? isr : irr;
            bus.data_oe  = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pic_interrupt_sequencer.sv
// ============================================================================
// Module      : tb_pic_interrupt_sequencer
// Description : Directed self-checking bench for the PIC interrupt core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pic_interrupt_sequencer;

    logic       clk;
    logic       reset_n;
    logic [7:0] imr;
    logic       init_done;
    logic       icw1_ltim;
    logic [4:0] icw2_vec;
    logic       icw4_aeoi;
    logic [7:0] ocw2;
    logic       ocw2_wr;
    logic [7:0] irr;
    logic [7:0] isr;

    int checks = 0;
    int errors = 0;

    pic_interrupt_sequencer_if bus ();

    pic_interrupt_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .imr       (imr),
        .init_done (init_done),
        .icw1_ltim (icw1_ltim),
        .icw2_vec  (icw2_vec),
        .icw4_aeoi (icw4_aeoi),
        .ocw2      (ocw2),
        .ocw2_wr   (ocw2_wr),
        .irr       (irr),
        .isr       (isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_ocw2(input logic [7:0] v);
        ocw2    = v;
        ocw2_wr = 1'b1;
        cyc(1);
        ocw2_wr = 1'b0;
        cyc(1);
    endtask

    task automatic pulse1(output logic oe);
        bus.inta_n = 1'b0;
        cyc(3);
        oe = bus.data_oe;
        bus.inta_n = 1'b1;
        cyc(3);
    endtask

    task automatic pulse2_low(output logic [7:0] vec, output logic oe);
        bus.inta_n = 1'b0;
        cyc(3);
        vec = bus.data_out;
        oe  = bus.data_oe;
    endtask

    task automatic inta_release();
        bus.inta_n = 1'b1;
        cyc(3);
    endtask

    task automatic inta_seq(output logic [7:0] vec, output logic oe1, output logic oe2);
        pulse1(oe1);
        pulse2_low(vec, oe2);
        inta_release();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        init_done = 1'b0;
        cyc(2);
        checks++;
        if ({bus.intr, bus.data_oe, bus.data_out, irr, isr} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: got int=%b oe=%b dout=%h irr=%h isr=%h, want all 0",
                     bus.intr, bus.data_oe, bus.data_out, irr, isr);
        end
        reset_n = 1'b1;
        bus.ir  = 8'h01;
        cyc(3);
        checks++;
        if (irr !== 8'h00 || bus.intr !== 1'b0) begin
            errors++;
            $display("FAIL init_hold: got irr=%h int=%b, want irr=00 int=0", irr, bus.intr);
        end
        bus.ir = 8'h00;
        cyc(1);
        init_done = 1'b1;
        cyc(1);
    endtask

    task automatic test_edge_basic();
        logic [7:0] vec;
        logic oe1, oe2;
        icw1_ltim = 1'b0;
        bus.ir = 8'h08;
        cyc(1);
        checks++;
        if (irr !== 8'h08 || bus.intr !== 1'b0) begin
            errors++;
            $display("FAIL edge_irr: got irr=%h int=%b, want irr=08 int=0", irr, bus.intr);
        end
        cyc(1);
        checks++;
        if (bus.intr !== 1'b1) begin
            errors++;
            $display("FAIL edge_int: got int=%b, want 1", bus.intr);
        end
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h43 || oe1 !== 1'b0 || oe2 !== 1'b1 || isr !== 8'h08) begin
            errors++;
            $display("FAIL edge_ack: got vec=%h oe1=%b oe2=%b isr=%h, want 43 0 1 08", vec, oe1, oe2, isr);
        end
        checks++;
        if (bus.data_oe !== 1'b0 || irr !== 8'h00) begin
            errors++;
            $display("FAIL edge_after: got oe=%b irr=%h, want 0 00", bus.data_oe, irr);
        end
        bus.ir = 8'h00;
        write_ocw2(8'h20);
        checks++;
        if (isr !== 8'h00 || bus.intr !== 1'b0) begin
            errors++;
            $display("FAIL edge_eoi: got isr=%h int=%b, want 00 0", isr, bus.intr);
        end
    endtask

    task automatic test_level_mask();
        logic [7:0] vec;
        logic oe1, oe2;
        icw1_ltim = 1'b1;
        imr = 8'h04;
        bus.ir = 8'h24;
        cyc(2);
        bus.rd_status_en = 1'b1;
        bus.ocw3_ris = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 8'h24 || bus.data_oe !== 1'b1) begin
            errors++;
            $display("FAIL status_irr: got dout=%h oe=%b, want 24 1", bus.data_out, bus.data_oe);
        end
        bus.rd_status_en = 1'b0;
        checks++;
        if (bus.intr !== 1'b1) begin
            errors++;
            $display("FAIL level_int: got int=%b, want 1", bus.intr);
        end
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h45 || isr !== 8'h20) begin
            errors++;
            $display("FAIL level_masked: got vec=%h isr=%h, want 45 20", vec, isr);
        end
        imr = 8'h00;
        cyc(2);
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h42 || isr !== 8'h24) begin
            errors++;
            $display("FAIL level_unmasked: got vec=%h isr=%h, want 42 24", vec, isr);
        end
        bus.rd_status_en = 1'b1;
        bus.ocw3_ris = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 8'h24) begin
            errors++;
            $display("FAIL status_isr: got dout=%h, want 24", bus.data_out);
        end
        bus.rd_status_en = 1'b0;
        bus.ocw3_ris = 1'b0;
        bus.ir = 8'h00;
        cyc(1);
        write_ocw2(8'h62);
        checks++;
        if (isr !== 8'h20) begin
            errors++;
            $display("FAIL specific_eoi: got isr=%h, want 20", isr);
        end
        write_ocw2(8'h65);
        checks++;
        if (isr !== 8'h00 || irr !== 8'h00) begin
            errors++;
            $display("FAIL level_clean: got isr=%h irr=%h, want 00 00", isr, irr);
        end
        icw1_ltim = 1'b0;
    endtask

    task automatic test_nested();
        logic [7:0] vec;
        logic oe1, oe2;
        bus.ir = 8'h10;
        cyc(2);
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h44 || isr !== 8'h10) begin
            errors++;
            $display("FAIL nested_first: got vec=%h isr=%h, want 44 10", vec, isr);
        end
        bus.ir = 8'h50;
        cyc(3);
        checks++;
        if (bus.intr !== 1'b0 || irr !== 8'h40) begin
            errors++;
            $display("FAIL nested_lower: got int=%b irr=%h, want 0 40", bus.intr, irr);
        end
        bus.ir = 8'h52;
        cyc(3);
        checks++;
        if (bus.intr !== 1'b1) begin
            errors++;
            $display("FAIL nested_higher: got int=%b, want 1", bus.intr);
        end
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h41 || isr !== 8'h12) begin
            errors++;
            $display("FAIL nested_ack: got vec=%h isr=%h, want 41 12", vec, isr);
        end
        bus.ir = 8'h00;
        cyc(1);
        write_ocw2(8'h20);
        checks++;
        if (isr !== 8'h10) begin
            errors++;
            $display("FAIL nested_eoi1: got isr=%h, want 10", isr);
        end
        write_ocw2(8'h20);
        write_ocw2(8'h20);
        checks++;
        if (isr !== 8'h00 || irr !== 8'h00) begin
            errors++;
            $display("FAIL nested_eoi2: got isr=%h irr=%h, want 00 00", isr, irr);
        end
    endtask

    task automatic test_aeoi_rotate();
        logic [7:0] vec;
        logic oe1, oe2;
        icw4_aeoi = 1'b1;
        write_ocw2(8'h80);
        bus.ir = 8'h03;
        cyc(2);
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h40 || isr !== 8'h00) begin
            errors++;
            $display("FAIL aeoi_first: got vec=%h isr=%h, want 40 00", vec, isr);
        end
        cyc(1);
        checks++;
        if (bus.intr !== 1'b1) begin
            errors++;
            $display("FAIL aeoi_int: got int=%b, want 1", bus.intr);
        end
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h41 || isr !== 8'h00) begin
            errors++;
            $display("FAIL aeoi_second: got vec=%h isr=%h, want 41 00", vec, isr);
        end
        bus.ir = 8'h00;
        icw4_aeoi = 1'b0;
        write_ocw2(8'h00);
        write_ocw2(8'hC7);
    endtask

    task automatic test_set_priority();
        logic [7:0] vec;
        logic oe1, oe2;
        write_ocw2(8'hC4);
        bus.ir = 8'h21;
        cyc(2);
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h45 || isr !== 8'h20) begin
            errors++;
            $display("FAIL setprio_first: got vec=%h isr=%h, want 45 20", vec, isr);
        end
        cyc(1);
        checks++;
        if (bus.intr !== 1'b0) begin
            errors++;
            $display("FAIL setprio_nested: got int=%b, want 0", bus.intr);
        end
        write_ocw2(8'h20);
        cyc(1);
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h40 || isr !== 8'h01) begin
            errors++;
            $display("FAIL setprio_second: got vec=%h isr=%h, want 40 01", vec, isr);
        end
        bus.ir = 8'h00;
        write_ocw2(8'h20);
        write_ocw2(8'hC7);
    endtask

    task automatic test_spurious_and_reset();
        logic [7:0] vec;
        logic oe1, oe2;
        bus.ir = 8'h04;
        cyc(2);
        checks++;
        if (bus.intr !== 1'b1) begin
            errors++;
            $display("FAIL spur_int: got int=%b, want 1", bus.intr);
        end
        bus.ir = 8'h00;
        cyc(2);
        checks++;
        if (bus.intr !== 1'b0 || irr !== 8'h00) begin
            errors++;
            $display("FAIL spur_withdraw: got int=%b irr=%h, want 0 00", bus.intr, irr);
        end
        inta_seq(vec, oe1, oe2);
        checks++;
        if (vec !== 8'h47 || isr !== 8'h00) begin
            errors++;
            $display("FAIL spur_vector: got vec=%h isr=%h, want 47 00", vec, isr);
        end
        bus.ir = 8'h04;
        cyc(2);
        pulse1(oe1);
        pulse2_low(vec, oe2);
        checks++;
        if (vec !== 8'h42 || oe2 !== 1'b1 || isr !== 8'h04) begin
            errors++;
            $display("FAIL mid_ack2: got vec=%h oe=%b isr=%h, want 42 1 04", vec, oe2, isr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.data_oe !== 1'b0 || isr !== 8'h00 || irr !== 8'h00 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got oe=%b isr=%h irr=%h dout=%h, want 0 00 00 00",
                     bus.data_oe, isr, irr, bus.data_out);
        end
        bus.ir = 8'h00;
        bus.inta_n = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        reset_n          = 1'b0;
        imr              = 8'h00;
        init_done        = 1'b0;
        icw1_ltim        = 1'b0;
        icw2_vec         = 5'b01000;
        icw4_aeoi        = 1'b0;
        ocw2             = 8'h00;
        ocw2_wr          = 1'b0;
        bus.ir           = 8'h00;
        bus.inta_n       = 1'b1;
        bus.rd_status_en = 1'b0;
        bus.ocw3_ris     = 1'b0;
        cyc(1);
        test_reset();
        test_edge_basic();
        test_level_mask();
        test_nested();
        test_aeoi_rotate();
        test_set_priority();
        test_spurious_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
